// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for a shared-datapath multicycle MIPS core, with memory wait/timeout handling.
// Define MIPS_CTRL_ILLEGAL_TRAP_EN to fault on illegal opcode/funct; otherwise they retire as NOPs.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_HALT   = 4'd12;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       busy;
  } ctrl_t;

  logic [3:0]        state;
  logic [3:0]        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_inc;
  logic              retire;
  logic              trap;
  logic              funct_ok;
  ctrl_t             ctrl;

  assign funct_ok  = (funct == FN_ADD) || (funct == FN_SUB) ||
                     (funct == FN_AND) || (funct == FN_OR);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      fault    <= 1'b0;
      retired  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (wait_inc)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (trap)
        fault <= 1'b1;
      if (retire)
        retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    wait_inc  = 1'b0;
    retire    = 1'b0;
    trap      = 1'b0;
    case (state)
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE; else wait_inc = 1'b1;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_J:         state_nxt = S_JUMP;
          default: begin
            if (TRAP_EN) begin trap = 1'b1; state_nxt = S_HALT;  end
            else         begin retire = 1'b1; state_nxt = S_FETCH; end
          end
        endcase
      end
      S_MEMADR: state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_nxt = S_MEMWB; else wait_inc = 1'b1;
      S_MEMWB:  begin retire = 1'b1; state_nxt = S_FETCH; end
      S_MEMWR: begin
        if (mem_ready) begin retire = 1'b1; state_nxt = S_FETCH; end
        else wait_inc = 1'b1;
      end
      S_EXEC: begin
        if (funct_ok)     state_nxt = S_ALUWB;
        else if (TRAP_EN) begin trap = 1'b1; state_nxt = S_HALT;  end
        else              begin retire = 1'b1; state_nxt = S_FETCH; end
      end
      S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_ADDIEX: state_nxt = S_ADDIWB;
      S_HALT:   state_nxt = S_HALT;
      default:  begin trap = 1'b1; state_nxt = S_HALT; end
    endcase
    // The final wait cycle times out unless mem_ready shows up in that same cycle.
    if (wait_inc && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1))) begin
      trap      = 1'b1;
      state_nxt = S_HALT;
    end
  end

  always_comb begin
    ctrl      = '0;
    ctrl.busy = 1'b1;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = 2'b10;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = 2'b10;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = 2'b10;
      end
      S_MEMRD:  begin ctrl.mem_read  = 1'b1; ctrl.iord = 1'b1; end
      S_MEMWB:  begin ctrl.reg_write = 1'b1; ctrl.mem_to_reg = 1'b1; end
      S_MEMWR:  begin ctrl.mem_write = 1'b1; ctrl.iord = 1'b1; end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_op = 2'b10;
          FN_SUB:  ctrl.alu_op = 2'b11;
          FN_AND:  ctrl.alu_op = 2'b01;
          default: ctrl.alu_op = 2'b00;
        endcase
      end
      S_ALUWB:  begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b11;
        ctrl.pc_src    = 2'b01;
        ctrl.pc_en     = zero;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JUMP:   begin ctrl.pc_en = 1'b1; ctrl.pc_src = 2'b10; end
      S_HALT:   ctrl.busy = 1'b0;
      default:  ;
    endcase
  end

  // Gating with rst_n keeps a mid-instruction reset from leaking any write strobe.
  assign {mem_read, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
          alu_op, reg_write, reg_dst, mem_to_reg, busy} = rst_n ? ctrl : '0;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: an instruction-level model expands each instruction
// into its expected per-cycle state/control trace, which is compared against the DUT.
module tb_mips_multicycle_ctrl;

  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 16;

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       opcode, funct;
  logic             zero, mem_ready;
  logic             mem_read, mem_write, iord, ir_write, pc_en;
  logic [1:0]       pc_src, alu_src_b, alu_op;
  logic             alu_src_a, reg_write, reg_dst, mem_to_reg, busy, fault;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state_dbg;
  logic [15:0]      ctrl_obs;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_retired = 0;
  bit exp_fault = 0;

  typedef struct {int st; bit rdy; bit z;} ent_t;
  ent_t sched[$];

  mips_multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .busy(busy), .fault(fault), .retired(retired),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign ctrl_obs = {mem_read, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a,
                     alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, busy};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal_funct(input logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h24, 6'h25};
  endfunction

  // Expected controls straight from the per-state action table.
  function automatic logic [15:0] exp_ctrl(input int st, input bit rdy, input bit z,
                                           input logic [5:0] fn);
    logic mr, mw, io, irw, pe, asa, rw, rd, m2r, bs;
    logic [1:0] ps, asb, op;
    {mr, mw, io, irw, pe, asa, rw, rd, m2r} = '0;
    ps = 2'b00; asb = 2'b00; op = 2'b00;
    bs = (st != 12);
    case (st)
      0:  begin mr = 1; asb = 2'b01; op = 2'b10; irw = rdy; pe = rdy; end
      1:  begin asb = 2'b11; op = 2'b10; end
      2, 9: begin asa = 1; asb = 2'b10; op = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; io = 1; end
      6:  begin
        asa = 1;
        op = (fn == 6'h20) ? 2'b10 : (fn == 6'h22) ? 2'b11 : (fn == 6'h24) ? 2'b01 : 2'b00;
      end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; op = 2'b11; ps = 2'b01; pe = z; end
      10: rw = 1;
      11: begin pe = 1; ps = 2'b10; end
      default: ;
    endcase
    return {mr, mw, io, irw, pe, ps, asa, asb, op, rw, rd, m2r, bs};
  endfunction

  task automatic push(input int st, input int r, input int zs);
    ent_t e;
    e.st  = st;
    e.rdy = (r < 0) ? 1'($urandom_range(0, 1)) : r[0];
    e.z   = (zs < 0) ? 1'($urandom_range(0, 1)) : zs[0];
    sched.push_back(e);
  endtask

  // Instruction-level model: expand one instruction into its cycle trace.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw,
                       input int mw, input int zs);
    bit illegal = 0;
    for (int j = 0; j < fw; j++) push(0, 0, zs);
    push(0, 1, zs);
    push(1, -1, zs);
    case (op)
      6'h23: begin
        push(2, -1, zs);
        for (int j = 0; j < mw; j++) push(3, 0, zs);
        push(3, 1, zs);
        push(4, -1, zs);
      end
      6'h2B: begin
        push(2, -1, zs);
        for (int j = 0; j < mw; j++) push(5, 0, zs);
        push(5, 1, zs);
      end
      6'h00: begin
        push(6, -1, zs);
        if (legal_funct(fn)) push(7, -1, zs); else illegal = 1;
      end
      6'h04: push(8, -1, zs);
      6'h08: begin push(9, -1, zs); push(10, -1, zs); end
      6'h02: push(11, -1, zs);
      default: illegal = 1;
    endcase
    if (illegal && TRAP_EN) begin
      push(12, -1, zs);
      exp_fault = 1;
    end else begin
      exp_retired++;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                           input int mw, input int zs);
    ent_t e;
    int base;
    base   = exp_retired;
    opcode = op;
    funct  = fn;
    build(op, fn, fw, mw, zs);
    while (sched.size() > 0) begin
      e = sched.pop_front();
      mem_ready = e.rdy;
      zero      = e.z;
      @(negedge clk);
      check("state", 32'(state_dbg), 32'(e.st));
      check("ctrl", 32'(ctrl_obs), 32'(exp_ctrl(e.st, e.rdy, e.z, fn)));
      check("retired_hold", 32'(retired), 32'(base % (1 << CNT_W)));
      @(posedge clk); #1;
    end
    check("retired", 32'(retired), 32'(exp_retired % (1 << CNT_W)));
    check("fault", 32'(fault), 32'(exp_fault));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_ctrl", 32'(ctrl_obs), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_retired = 0;
    exp_fault   = 0;
  endtask

  initial begin
    logic [5:0] fns [4];
    logic [5:0] op, fn;
    int k, fw, mw;
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25;
    rst_n = 1'b1; opcode = '0; funct = '0; zero = 0; mem_ready = 0;
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    apply_reset();

    // LW 0x8C010004 with memory always ready
    run_instr(6'h23, 6'h04, 0, 0, 0);
    // SW with three wait cycles in MEMWR
    run_instr(6'h2B, 6'h04, 0, 3, 0);
    run_instr(6'h04, 6'h00, 0, 0, 1);
    run_instr(6'h04, 6'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) run_instr(6'h00, fns[i], 0, 0, -1);
    // mem_ready on the last allowed wait cycle must not fault
    run_instr(6'h23, 6'h00, MEM_TIMEOUT - 1, MEM_TIMEOUT - 1, -1);

    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 7);
      if (TRAP_EN && k >= 6) k = k - 6;
      fw = ($urandom_range(0, 7) == 0) ? MEM_TIMEOUT - 1 : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 7) == 0) ? MEM_TIMEOUT - 1 : int'($urandom_range(0, 3));
      fn = 6'($urandom);
      case (k)
        0: op = 6'h23;
        1: op = 6'h2B;
        2: begin op = 6'h00; fn = fns[$urandom_range(0, 3)]; end
        3: op = 6'h04;
        4: op = 6'h08;
        5: op = 6'h02;
        6: op = 6'h30 + 6'($urandom_range(0, 15));
        default: begin op = 6'h00; fn = 6'h00 + 6'($urandom_range(0, 15)); end
      endcase
      run_instr(op, fn, fw, mw, -1);
    end

    // Illegal opcode 0x3F
    run_instr(6'h3F, 6'h00, 0, 0, -1);
    check("illegal_busy", 32'(busy), TRAP_EN ? 32'd0 : 32'd1);
    apply_reset();

    // Reset during a stalled store kills the write strobe immediately
    opcode = 6'h2B; funct = 6'h00; mem_ready = 1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 0;
    @(negedge clk);
    check("mid_state", 32'(state_dbg), 32'd5);
    check("mid_mem_write", 32'(mem_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_mem_write", 32'(mem_write), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'd0);
    @(posedge clk); #1;
    apply_reset();
    run_instr(6'h08, 6'h00, 1, 0, -1);

    // Memory timeout in FETCH
    mem_ready = 0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      @(negedge clk);
      check("to_wait_state", 32'(state_dbg), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("to_state", 32'(state_dbg), 32'd12);
    check("to_fault", 32'(fault), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    mem_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("to_stuck", 32'(state_dbg), 32'd12);
    @(posedge clk); #1;
    apply_reset();
    run_instr(6'h02, 6'h00, 0, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style control FSM that sequences the shared multicycle MIPS datapath: PC, instruction register, register file, single ALU and unified memory.
- Decodes OpCode (RTYPE, J, BEQ, ADDI, LW, SW) and Funct (ADD, SUB, AND, OR) from the definitions package.
- Drives per-cycle datapath enables and muxes, handles a memory ready handshake, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ready before the FSM faults.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], OpCode enum
- funct  in  6  IR[5:0], Funct enum
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- iord  out  1  memory address mux: 0=PC, 1=ALUOut
- ir_write  out  1  load instruction register
- pc_en  out  1  PC load enable (final, branch-qualified)
- pc_src  out  2  00=ALU result (PC+4), 01=ALUOut (branch target), 10=jump address
- alu_src_a  out  1  0=PC, 1=rs data
- alu_src_b  out  2  00=rt data, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  2  00=OR, 01=AND, 10=ADD, 11=SUB
- reg_write  out  1  register file write enable
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- busy  out  1  high in every state except HALT
- fault  out  1  sticky; memory timeout or illegal instruction
- retired  out  CNT_W  count of completed instructions
- state_dbg  out  4  current state encoding

Behaviour:
- Reset: asynchronous, active-low on rst_n. State=FETCH, wait counter=0, fault=0, retired=0. While rst_n is low, all control outputs are 0.
- Control outputs are combinational from the registered state, plus mem_ready and zero where noted. Unlisted outputs are 0.
- State encoding and actions:
  - FETCH (0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=10. On mem_ready, ir_write=1, pc_en=1, pc_src=00, and go to DECODE; otherwise stay.
  - DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=10 (precompute branch target). Next state by opcode: LW/SW→MEMADR, RTYPE→EXEC, BEQ→BRANCH, ADDI→ADDIEX, J→JUMP, other→illegal handling.
  - MEMADR (2): alu_src_a=1, alu_src_b=10, alu_op=10. LW→MEMRD, SW→MEMWR.
  - MEMRD (3): mem_read=1, iord=1. On mem_ready go to MEMWB; otherwise stay.
  - MEMWB (4): reg_write=1, reg_dst=0, mem_to_reg=1. Retire, then FETCH.
  - MEMWR (5): mem_write=1, iord=1. On mem_ready, retire and go to FETCH.
  - EXEC (6): alu_src_a=1, alu_src_b=00. alu_op from funct: ADD→10, SUB→11, AND→01, OR→00. Then ALUWB; other funct→illegal handling.
  - ALUWB (7): reg_write=1, reg_dst=1, mem_to_reg=0. Retire, then FETCH.
  - BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=11, pc_src=01, pc_en=zero. Retire, then FETCH.
  - ADDIEX (9): alu_src_a=1, alu_src_b=10, alu_op=10. Then ADDIWB.
  - ADDIWB (10): reg_write=1, reg_dst=0, mem_to_reg=0. Retire, then FETCH.
  - JUMP (11): pc_en=1, pc_src=10. Retire, then FETCH.
  - HALT (12): all controls 0, busy=0. Exit only via reset.
- Wait counter:
  - Increments each cycle a memory state (FETCH, MEMRD, MEMWR) waits without mem_ready. Clears on state change.
  - Counter reaching MEM_TIMEOUT while mem_ready is still low sets fault and moves to HALT. mem_ready arriving on the same cycle wins: no fault.
- Retire: retired increments by 1 on the exit cycle of MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, ADDIWB and JUMP. Wraps modulo 2^CNT_W.
- Reset asserted mid-instruction aborts immediately. No partial write occurs after rst_n falls.
- Unused encodings 13–15 go to HALT with fault=1.

Optional Feature:
- Macro: MIPS_CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode (in DECODE) or illegal funct (in EXEC) sets fault=1 and enters HALT. The instruction is not retired.
- Undefined: the illegal instruction executes as a NOP. The FSM returns to FETCH, retired increments, and fault is unaffected.

Test Plan:
- Reset, then fetch/retire timing:
  - Stimulus: release rst_n; mem_ready=1 every cycle; issue instruction 0x8C010004 (LW).
  - Required: state sequence 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 in MEMWB; retired=1.
- Memory wait states:
  - Stimulus: SW with mem_ready low for 3 cycles in MEMWR.
  - Required: mem_write=1 and iord=1 held for 4 cycles; retire only on the mem_ready cycle.
- BEQ, both outcomes:
  - Stimulus: BEQ with zero=1, then BEQ with zero=0.
  - Required: pc_en=1 and pc_src=01 in BRANCH for the first; pc_en=0 for the second; retired increments both times.
- R-type funct decode:
  - Stimulus: RTYPE with funct 0x20, 0x22, 0x24, 0x25.
  - Required: alu_op in EXEC = 10, 11, 01, 00 respectively.
- Memory timeout:
  - Stimulus: mem_ready held 0 in FETCH.
  - Required: after MEM_TIMEOUT cycles, state=12, fault=1, busy=0; only rst_n recovers (state=0, fault=0, retired=0).
- Illegal opcode 0x3F:
  - Required with MIPS_CTRL_ILLEGAL_TRAP_EN defined: HALT, fault=1.
  - Required without it: FETCH next, retired+1, fault=0.
